// File: rtl/elevador_pkg.sv
// Shared types and floor codes for the elevator FSM and its call controller.
// Floor code 0 means "no floor"; valid floors are 1..3.
package elevador_pkg;

    typedef logic [1:0] andar_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DOOR  = 2'd2
    } estado_chamada_t;

    localparam andar_t ANDAR_NENHUM = 2'd0;
    localparam andar_t ANDAR1       = 2'd1;
    localparam andar_t ANDAR2       = 2'd2;
    localparam andar_t ANDAR3       = 2'd3;

    // One-hot call-bit mask for a floor code; floor 0 maps to no bit.
    function automatic logic [2:0] andar_mask(input andar_t a);
        logic [2:0] m;
        m = 3'b000;
        case (a)
            ANDAR1:  m = 3'b001;
            ANDAR2:  m = 3'b010;
            ANDAR3:  m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/seletor_andar.sv
// Combinational SCAN target selection: keeps the current direction while calls remain ahead of the car.
// Only meaningful when at least one call is pending and none is at the current floor.
module seletor_andar
    import elevador_pkg::*;
(
    input  logic [2:0] i_pendente,
    input  andar_t     i_andar,
    input  logic       i_dir_up,
    output andar_t     o_alvo,
    output logic       o_dir_up
);

    andar_t w_acima;
    andar_t w_abaixo;

    always_comb begin
        // Later assignments override earlier ones, so the closest floor wins.
        w_acima = ANDAR_NENHUM;
        if (i_pendente[2] && (i_andar < ANDAR3)) w_acima = ANDAR3;
        if (i_pendente[1] && (i_andar < ANDAR2)) w_acima = ANDAR2;
        if (i_pendente[0] && (i_andar < ANDAR1)) w_acima = ANDAR1;

        w_abaixo = ANDAR_NENHUM;
        if (i_pendente[0] && (i_andar > ANDAR1)) w_abaixo = ANDAR1;
        if (i_pendente[1] && (i_andar > ANDAR2)) w_abaixo = ANDAR2;

        if (i_dir_up && (w_acima != ANDAR_NENHUM)) begin
            o_alvo   = w_acima;
            o_dir_up = 1'b1;
        end else if (w_abaixo != ANDAR_NENHUM) begin
            o_alvo   = w_abaixo;
            o_dir_up = 1'b0;
        end else begin
            o_alvo   = w_acima;
            o_dir_up = 1'b1;
        end
    end

endmodule

// File: rtl/elevador_chamadas.sv
// Floor-call controller: latches hall calls, drives a frozen SCAN target until arrival at rest, then door dwell.
// All outputs registered; macro ELEVADOR_CANCEL_EN adds the cancel input (ignored while the door is open).
module elevador_chamadas
    import elevador_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int NANDARES     = 3
) (
    input  logic                clk_1,
    input  logic                reset,
    input  logic [NANDARES-1:0] btn,
    input  andar_t              andar,
    input  logic                sobe,
    input  logic                desce,
`ifdef ELEVADOR_CANCEL_EN
    input  logic                cancel,
`endif
    output andar_t              ir,
    output logic                req_valid,
    output logic                porta,
    output logic [NANDARES-1:0] pendente
);

    localparam logic [3:0] DWELL_LOAD = 4'(DWELL_CYCLES - 1);

    estado_chamada_t     r_estado;
    estado_chamada_t     w_estado_n;
    andar_t              r_alvo;
    andar_t              w_alvo_n;
    logic                r_dir_up;
    logic                w_dir_up_n;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_n;
    logic [NANDARES-1:0] r_btn_q;
    logic [NANDARES-1:0] r_pendente;
    logic [NANDARES-1:0] w_pend_n;
    logic [NANDARES-1:0] w_rise;
    logic [NANDARES-1:0] w_alvo_mask;
    logic [NANDARES-1:0] w_andar_mask;
    logic                w_cancel;
    logic                w_chegou;
    andar_t              w_sel_alvo;
    logic                w_sel_dir_up;
    andar_t              r_ir;
    logic                r_req_valid;
    logic                r_porta;

    seletor_andar u_seletor (
        .i_pendente (r_pendente),
        .i_andar    (andar),
        .i_dir_up   (r_dir_up),
        .o_alvo     (w_sel_alvo),
        .o_dir_up   (w_sel_dir_up)
    );

    always_comb begin
        w_rise       = btn & ~r_btn_q;
        w_alvo_mask  = andar_mask(r_alvo);
        w_andar_mask = andar_mask(andar);
        w_chegou     = (andar == r_alvo) && !sobe && !desce && (andar != ANDAR_NENHUM);
        w_cancel     = 1'b0;
`ifdef ELEVADOR_CANCEL_EN
        w_cancel     = cancel && (r_estado != DOOR);
`endif
        w_estado_n = r_estado;
        w_alvo_n   = r_alvo;
        w_dir_up_n = r_dir_up;
        w_cnt_n    = r_cnt;
        w_pend_n   = r_pendente | w_rise;

        if (w_cancel) begin
            w_estado_n = IDLE;
            w_pend_n   = (r_pendente | w_rise) & w_andar_mask;
        end else begin
            case (r_estado)
                IDLE: begin
                    if ((r_pendente & w_andar_mask) != '0) begin
                        // Call at the current floor: open directly; a same-cycle press re-latches.
                        w_estado_n = DOOR;
                        w_alvo_n   = andar;
                        w_cnt_n    = DWELL_LOAD;
                        w_pend_n   = (r_pendente & ~w_andar_mask) | w_rise;
                    end else if (r_pendente != '0) begin
                        w_estado_n = SERVE;
                        w_alvo_n   = w_sel_alvo;
                        w_dir_up_n = w_sel_dir_up;
                    end
                end
                SERVE: begin
                    if (w_chegou) begin
                        w_estado_n = DOOR;
                        w_cnt_n    = DWELL_LOAD;
                        w_pend_n   = (r_pendente | w_rise) & ~w_alvo_mask;
                    end
                end
                DOOR: begin
                    // A press on the served floor keeps the door open instead of re-latching.
                    w_pend_n = r_pendente | (w_rise & ~w_alvo_mask);
                    if ((w_rise & w_alvo_mask) != '0) begin
                        w_cnt_n = DWELL_LOAD;
                    end else if (r_cnt == 4'd0) begin
                        w_estado_n = IDLE;
                    end else begin
                        w_cnt_n = r_cnt - 4'd1;
                    end
                end
                default: w_estado_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1) begin
        if (!reset) begin
            r_estado    <= IDLE;
            r_alvo      <= ANDAR_NENHUM;
            r_dir_up    <= 1'b1;
            r_cnt       <= 4'd0;
            r_btn_q     <= '0;
            r_pendente  <= '0;
            r_ir        <= ANDAR_NENHUM;
            r_req_valid <= 1'b0;
            r_porta     <= 1'b0;
        end else begin
            r_estado    <= w_estado_n;
            r_alvo      <= w_alvo_n;
            r_dir_up    <= w_dir_up_n;
            r_cnt       <= w_cnt_n;
            r_btn_q     <= btn;
            r_pendente  <= w_pend_n;
            r_ir        <= (w_estado_n == IDLE) ? ANDAR_NENHUM : w_alvo_n;
            r_req_valid <= (w_estado_n == SERVE);
            r_porta     <= (w_estado_n == DOOR);
        end
    end

    assign ir        = r_ir;
    assign req_valid = r_req_valid;
    assign porta     = r_porta;
    assign pendente  = r_pendente;

endmodule

// File: doc/elevador_chamadas.md
# elevador_chamadas

Floor-call controller for the three-floor elevator FSM. It sits in front of the elevator and drives its 2-bit target-floor input. It latches hall-button presses and picks the next target with direction-preserving (SCAN) priority. It holds the target stable until the elevator reports arrival at rest, then runs a door-dwell interval and clears the served call.

## Interface
- `DWELL_CYCLES`, 4: door-open interval in cycles; legal range 1–15.
- `NANDARES`, 3: number of floors; fixed at 3 because floor codes are 2 bits.
- `clk_1`  in  1: elevator clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-low; sampled on the `clk_1` rising edge.
- `btn`  in  3: hall buttons; `btn[0]` is floor 1, `btn[1]` floor 2, `btn[2]` floor 3; level inputs from switches.
- `andar`  in  2: elevator's current floor (1–3); 0 is invalid.
- `sobe`, `desce`  in  1 each: elevator motion flags.
- `ir`  out  2: target floor to the elevator; 0 means no request.
- `req_valid`  out  1: high while a target is being driven (SERVE).
- `porta`  out  1: door open (DOOR state).
- `pendente`  out  3: latched calls, same bit order as `btn`; intended for LEDs.
- `cancel`  in  1: exists only with `ELEVADOR_CANCEL_EN`.

## Operation
- **Call latching**
  - Register `btn` as `btn_q`.
  - A rising edge on button f (`btn[f] & ~btn_q[f]`) sets `pendente[f]`.
  - Holding a switch high does not re-latch after service.
- **Direction memory** `dir_up`; reset value 1.
- **States:** IDLE, SERVE, DOOR.
- **IDLE**, with no pending call: stay.
- **IDLE**, with `pendente` bit for `andar` set: go to DOOR with target = `andar`.
- **IDLE**, otherwise (target selection):
  - If `dir_up` and any call is above `andar`: target = nearest above.
  - Else if any call is below: target = nearest below, `dir_up` <= 0.
  - Else: target = nearest above, `dir_up` <= 1.
  - Go to SERVE.
- **SERVE**
  - `ir` = target and `req_valid` = 1.
  - Target is frozen; calls arriving meanwhile are only latched.
  - Arrival is `andar` == target and `sobe` == 0 and `desce` == 0 in the same cycle. On arrival go to DOOR.
  - `andar` == 0 is never arrival.
- **DOOR**
  - `porta` = 1 and `ir` = target, so the elevator holds position.
  - Clear the target's pending bit on entry.
  - Load the dwell counter with `DWELL_CYCLES`-1 and decrement each cycle; at 0 go to IDLE.
  - A rising edge on the target floor's button during DOOR reloads the counter and does not set the pending bit.
- **Simultaneous events**
  - Several rising edges in one cycle all latch.
  - A press on a floor in the same cycle its bit is cleared: the clear wins, unless the state is IDLE (then the set wins).
- **Reset values:** state = IDLE, `pendente` = 000, `ir` = 0, `req_valid` = 0, `porta` = 0, `dir_up` = 1, `btn_q` = 000, counter = 0. A reset in any state aborts immediately.

## Timing
- A button edge sampled at edge n shows in `pendente` after edge n.
- IDLE→SERVE takes one further edge, so `ir` and `req_valid` are valid after edge n+1.
- The elevator latches `ir` one cycle later. Its flags drop one cycle after arrival, so the arrival check passes no earlier than two cycles after `andar` matches.
- `porta` stays high for exactly `DWELL_CYCLES` cycles, unless reloaded.
- IDLE lasts at least one cycle between services.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- **With `ELEVADOR_CANCEL_EN`:**
  - The `cancel` port exists and is active-high.
  - In IDLE or SERVE, `cancel` clears all `pendente` bits except the `andar` bit and returns the state to IDLE. `ir` becomes 0 on the next edge.
  - In DOOR, `cancel` is ignored.
- **Without the macro:** no `cancel` port and no cancel logic.

## Structure
- The shared package `elevador_pkg` holds:
  - typedef `andar_t` (logic [1:0]);
  - enum `estado_chamada_t` {IDLE, SERVE, DOOR};
  - constants `ANDAR_NENHUM` = 0, `ANDAR1`..`ANDAR3`.
  - The elevator FSM also imports this package.
- One sub-module, `seletor_andar`: purely combinational next-target/direction logic. Inputs are `pendente`, `andar` and `dir_up`; outputs are target and new `dir_up`.

## Test plan
- Reset low for 2 cycles, then high → `ir` = 0, `pendente` = 000, `porta` = 0, `req_valid` = 0.
- At `andar` = 1, press floor 3 → `pendente` = 100, `ir` = 3 two edges after the press. With the elevator model, `porta` is high for 4 cycles once `andar` = 3 and the flags are 0; then `pendente` = 000.
- At `andar` = 2 with `dir_up` = 1, press floors 1 and 3 in the same cycle → target 3 first, then 1.
- At `andar` = 2, press floor 2 → DOOR directly, and `ir` stays 2.
- During DOOR at floor 3, press floor 3 at dwell count 1 → dwell restarts, giving `porta` high for 5+ cycles total.
- Assert reset mid-SERVE with `ir` = 3 → all outputs return to reset values on the next edge. With `ELEVADOR_CANCEL_EN`, `cancel` in SERVE sets `ir` = 0 and keeps only the `andar` bit of `pendente`.
